// File: rtl/slc3_input_conditioner_pkg.sv
// Shared types and constants for the SLC-3 board-input conditioning logic.
// Latency: n/a (declarations only).
// Backpressure: n/a; inputs are free-running levels with no handshake.
package slc3_io_pkg;

    // Per-button debounce FSM states
    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } key_state_t;

    // Short debounce window used by simulation benches instead of 5 ms
    localparam int DEBOUNCE_CYCLES_SIM = 4;

endpackage

// File: rtl/slc3_input_conditioner_if.sv
// Bundles raw board pins and their conditioned counterparts for the input conditioner.
// Latency: n/a (wiring only).
// Backpressure: none; every signal is a level or a one-cycle strobe.
interface slc3_input_conditioner_if #(
    parameter int SW_WIDTH = 10
);
    logic                Run_raw;
    logic                Continue_raw;
    logic [SW_WIDTH-1:0] SW_raw;
    logic                Run;
    logic                Continue;
    logic                Run_press;
    logic                Continue_press;
    logic [SW_WIDTH-1:0] SW;

    // Board side: drives raw pins, observes conditioned outputs
    modport master (
        output Run_raw, Continue_raw, SW_raw,
        input  Run, Continue, Run_press, Continue_press, SW
    );

    // Conditioner side: consumes raw pins, produces conditioned outputs
    modport slave (
        input  Run_raw, Continue_raw, SW_raw,
        output Run, Continue, Run_press, Continue_press, SW
    );
endinterface

// File: rtl/slc3_input_conditioner_key_debounce.sv
// Synchronises and debounces one active-low push-button, producing a clean level and a press strobe.
// Latency: SYNC_STAGES + DEBOUNCE_CYCLES + 1 edges from a clean raw edge to the level/strobe.
// Backpressure: none; the strobe is a single-cycle pulse that is never held.
module key_debounce
    import slc3_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic key_raw,
    output logic key_level,
    output logic key_press
);
    localparam int             CW      = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    key_state_t             state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   press_q, press_d;

    // Synchroniser chain, preset to "not pressed" so reset can never look like a press
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], key_raw};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // State, counter and strobe registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= RELEASED;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    // Next-state logic; the counter saturates at CNT_MAX because the state leaves the wait there
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        press_d = 1'b0;
        case (state_q)
            RELEASED: begin
                if (!s) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                if (s) begin
                    state_d = RELEASED;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = PRESSED;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            PRESSED: begin
                if (s) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (!s) begin
                    state_d = PRESSED;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = RELEASED;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = RELEASED;
                cnt_d   = '0;
            end
        endcase
    end

    // Level is a pure decode of the registered state, so it is glitch-free
    assign key_level = !((state_q == PRESSED) || (state_q == RELEASE_WAIT));
    assign key_press = press_q;

endmodule

// File: rtl/slc3_input_conditioner.sv
// Conditions Run/Continue buttons and slide switches: synchronise, debounce, emit clean levels and press strobes.
// Latency: SYNC_STAGES + DEBOUNCE_CYCLES + 1 edges from a clean raw change to any output.
// Backpressure: none; outputs are levels plus single-cycle strobes, consumers must sample every cycle.
module slc3_input_conditioner
    import slc3_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int SYNC_STAGES     = 2,
    parameter int SW_WIDTH        = 10
) (
    input  logic                    Clk,
    input  logic                    Reset_n,
    slc3_input_conditioner_if.slave io
);
    localparam int            CW      = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic                run_level, run_press;
    logic                cont_level, cont_press;
    logic [SW_WIDTH-1:0] sw_sync_q [SYNC_STAGES];
    logic [SW_WIDTH-1:0] v;
    logic [SW_WIDTH-1:0] sw_prev_q;
    logic [SW_WIDTH-1:0] sw_q;
    logic [CW-1:0]       sw_cnt_q;

    key_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .SYNC_STAGES     (SYNC_STAGES)
    ) u_run (
        .clk       (Clk),
        .reset_n   (Reset_n),
        .key_raw   (io.Run_raw),
        .key_level (run_level),
        .key_press (run_press)
    );

    key_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .SYNC_STAGES     (SYNC_STAGES)
    ) u_continue (
        .clk       (Clk),
        .reset_n   (Reset_n),
        .key_raw   (io.Continue_raw),
        .key_level (cont_level),
        .key_press (cont_press)
    );

    // Switch synchroniser: a vector of per-bit chains, all preset to 0
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sw_sync_q[i] <= '0;
            end
        end else begin
            sw_sync_q[0] <= io.SW_raw;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sw_sync_q[i] <= sw_sync_q[i-1];
            end
        end
    end

    assign v = sw_sync_q[SYNC_STAGES-1];

    // Shared stability counter: any bit change restarts it, so SW only ever updates as a whole vector
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            sw_prev_q <= '0;
            sw_cnt_q  <= '0;
            sw_q      <= '0;
        end else begin
            sw_prev_q <= v;
            if (v != sw_prev_q) begin
                sw_cnt_q <= '0;
            end else if (sw_cnt_q == CNT_MAX) begin
                sw_q <= v;
            end else begin
                sw_cnt_q <= sw_cnt_q + CW'(1);
            end
        end
    end

    assign io.Run            = run_level;
    assign io.Continue       = cont_level;
    assign io.Run_press      = run_press;
    assign io.Continue_press = cont_press;
    assign io.SW             = sw_q;

endmodule

// File: tb/tb_slc3_input_conditioner.sv
// Directed bench for the input conditioner with a 4-cycle debounce window and 2-stage synchronisers.
// Latency: expected output change 7 edges after a raw change.
// Backpressure: n/a.
module tb_slc3_input_conditioner;
    import slc3_io_pkg::*;

    logic Clk;
    logic Reset_n;

    slc3_input_conditioner_if #(.SW_WIDTH(10)) io ();

    slc3_input_conditioner #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES_SIM),
        .SYNC_STAGES     (2),
        .SW_WIDTH        (10)
    ) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .io      (io)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       rst_n;
        logic       run_raw;
        logic       cont_raw;
        logic [9:0] sw_raw;
        logic       run;
        logic       cont;
        logic       rp;
        logic       cp;
        logic [9:0] sw;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic rr, input logic cr, input logic [9:0] swr,
                       input logic er, input logic ec, input logic erp, input logic ecp,
                       input logic [9:0] esw);
        vec_t t;
        t.rst_n = r; t.run_raw = rr; t.cont_raw = cr; t.sw_raw = swr;
        t.run = er; t.cont = ec; t.rp = erp; t.cp = ecp; t.sw = esw;
        tbl.push_back(t);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // One active edge, then settle before sampling
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int n_run, n_cont, c_run, c_cont;

        Reset_n         = 1'b0;
        io.Run_raw      = 1'b0;
        io.Continue_raw = 1'b1;
        io.SW_raw       = 10'h000;

        // Reset held 3 edges with Run pressed: idle outputs throughout
        for (int i = 0; i < 3; i++) add(1'b0, 1'b0, 1'b1, 10'h000, 1'b1, 1'b1, 1'b0, 1'b0, 10'h000);
        // Release reset with Run released: no strobe
        for (int i = 0; i < 9; i++) add(1'b1, 1'b1, 1'b1, 10'h000, 1'b1, 1'b1, 1'b0, 1'b0, 10'h000);
        // Clean Run press: level and strobe appear on edge 7, strobe lasts one cycle
        for (int i = 1; i <= 6; i++) add(1'b1, 1'b0, 1'b1, 10'h000, 1'b1, 1'b1, 1'b0, 1'b0, 10'h000);
        add(1'b1, 1'b0, 1'b1, 10'h000, 1'b0, 1'b1, 1'b1, 1'b0, 10'h000);
        add(1'b1, 1'b0, 1'b1, 10'h000, 1'b0, 1'b1, 1'b0, 1'b0, 10'h000);
        add(1'b1, 1'b0, 1'b1, 10'h000, 1'b0, 1'b1, 1'b0, 1'b0, 10'h000);
        // Clean Run release: level returns on edge 7, no strobe
        for (int i = 1; i <= 6; i++) add(1'b1, 1'b1, 1'b1, 10'h000, 1'b0, 1'b1, 1'b0, 1'b0, 10'h000);
        add(1'b1, 1'b1, 1'b1, 10'h000, 1'b1, 1'b1, 1'b0, 1'b0, 10'h000);
        add(1'b1, 1'b1, 1'b1, 10'h000, 1'b1, 1'b1, 1'b0, 1'b0, 10'h000);

        for (int i = 0; i < tbl.size(); i++) begin
            Reset_n         = tbl[i].rst_n;
            io.Run_raw      = tbl[i].run_raw;
            io.Continue_raw = tbl[i].cont_raw;
            io.SW_raw       = tbl[i].sw_raw;
            step();
            chk($sformatf("tbl%0d_run", i),  32'(io.Run),            32'(tbl[i].run));
            chk($sformatf("tbl%0d_cont", i), 32'(io.Continue),       32'(tbl[i].cont));
            chk($sformatf("tbl%0d_rp", i),   32'(io.Run_press),      32'(tbl[i].rp));
            chk($sformatf("tbl%0d_cp", i),   32'(io.Continue_press), 32'(tbl[i].cp));
            chk($sformatf("tbl%0d_sw", i),   32'(io.SW),             32'(tbl[i].sw));
        end

        // Bounce: low 2, high 1, low 2, then high -> nothing accepted
        for (int i = 0; i < 16; i++) begin
            io.Run_raw = (i == 0 || i == 1 || i == 3 || i == 4) ? 1'b0 : 1'b1;
            step();
            chk($sformatf("bounce%0d_run", i), 32'(io.Run),       32'd1);
            chk($sformatf("bounce%0d_rp", i),  32'(io.Run_press), 32'd0);
        end

        // Hold Continue 50 cycles: exactly one strobe, on edge 7
        io.Continue_raw = 1'b0;
        n_cont = 0; c_cont = -1;
        for (int c = 1; c <= 50; c++) begin
            step();
            if (io.Continue_press) begin
                n_cont++;
                if (c_cont < 0) c_cont = c;
            end
        end
        chk("hold_strobe_count", 32'(n_cont), 32'd1);
        chk("hold_strobe_edge",  32'(c_cont), 32'd7);
        chk("hold_level",        32'(io.Continue), 32'd0);
        io.Continue_raw = 1'b1;
        n_cont = 0;
        for (int c = 1; c <= 10; c++) begin
            step();
            if (io.Continue_press) n_cont++;
            if (c == 6) chk("release_level_e6", 32'(io.Continue), 32'd0);
            if (c == 7) chk("release_level_e7", 32'(io.Continue), 32'd1);
        end
        chk("release_no_strobe", 32'(n_cont), 32'd0);
        // Second press yields a second strobe
        io.Continue_raw = 1'b0;
        n_cont = 0;
        for (int c = 1; c <= 12; c++) begin
            step();
            if (io.Continue_press) n_cont++;
        end
        chk("second_press_count", 32'(n_cont), 32'd1);
        io.Continue_raw = 1'b1;
        for (int c = 1; c <= 10; c++) step();
        chk("second_release_level", 32'(io.Continue), 32'd1);

        // Switches: stable 0x00B appears on edge 7
        io.SW_raw = 10'h00B;
        for (int c = 1; c <= 7; c++) begin
            step();
            chk($sformatf("sw00b_e%0d", c), 32'(io.SW), (c == 7) ? 32'h00B : 32'h000);
        end
        // Bit 0 toggling every 2 cycles never settles
        for (int i = 0; i < 20; i++) begin
            io.SW_raw = (((i >> 1) & 1) == 0) ? 10'h00A : 10'h00B;
            step();
            chk($sformatf("swtog%0d", i), 32'(io.SW), 32'h00B);
        end
        // Settle at 0x3FF: whole vector jumps together on edge 7
        io.SW_raw = 10'h3FF;
        for (int c = 1; c <= 8; c++) begin
            step();
            chk($sformatf("sw3ff_e%0d", c), 32'(io.SW), (c >= 7) ? 32'h3FF : 32'h00B);
        end

        // Simultaneous press: both strobes on the same edge
        io.Run_raw = 1'b0;
        io.Continue_raw = 1'b0;
        n_run = 0; n_cont = 0; c_run = -1; c_cont = -1;
        for (int c = 1; c <= 12; c++) begin
            step();
            if (io.Run_press)      begin n_run++;  c_run  = c; end
            if (io.Continue_press) begin n_cont++; c_cont = c; end
        end
        chk("simul_run_count",  32'(n_run),  32'd1);
        chk("simul_cont_count", 32'(n_cont), 32'd1);
        chk("simul_run_edge",   32'(c_run),  32'd7);
        chk("simul_cont_edge",  32'(c_cont), 32'd7);
        io.Run_raw = 1'b1;
        io.Continue_raw = 1'b1;
        for (int c = 1; c <= 10; c++) step();
        chk("simul_released", 32'({io.Run, io.Continue}), 32'd3);

        // Reset during PRESS_WAIT: no strobe, FSM back to RELEASED
        io.Run_raw = 1'b0;
        for (int c = 1; c <= 4; c++) step();
        Reset_n = 1'b0;
        io.Run_raw = 1'b1;
        n_run = 0;
        for (int c = 1; c <= 2; c++) begin
            step();
            if (io.Run_press) n_run++;
        end
        Reset_n = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            step();
            if (io.Run_press) n_run++;
        end
        chk("rst_pw_no_strobe", 32'(n_run), 32'd0);
        chk("rst_pw_level",     32'(io.Run), 32'd1);
        // Fresh press needs the full 7 edges, proving the count restarted from RELEASED
        io.Run_raw = 1'b0;
        c_run = -1;
        for (int c = 1; c <= 10; c++) begin
            step();
            if (io.Run_press && c_run < 0) c_run = c;
        end
        chk("rst_pw_repress_edge", 32'(c_run), 32'd7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
